// File: rtl/snake_pkg.sv
// Shared snake-engine definitions: FSM state encoding and default timing constants
// used by the tick generator and the VGA/CPU timing blocks.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam int unsigned BASE_PERIOD_DEF     = 25_000_000;
    localparam int unsigned STEP_DEF            = 3_000_000;
    localparam int unsigned MIN_PERIOD_DEF      = 1_000_000;
    localparam int unsigned LEVEL_W_DEF         = 3;
    localparam int unsigned CNT_W_DEF           = 32;
    localparam int unsigned TICKS_PER_LEVEL_DEF = 64;

endpackage

// File: rtl/speed_period_calc.sv
// Combinational speed level -> tick period, clamped at MIN_PERIOD by a compare
// so a large level can never wrap the subtraction.
module speed_period_calc
    import snake_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = BASE_PERIOD_DEF,
    parameter int unsigned STEP        = STEP_DEF,
    parameter int unsigned MIN_PERIOD  = MIN_PERIOD_DEF,
    parameter int unsigned LEVEL_W     = LEVEL_W_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic [LEVEL_W-1:0] level,
    output logic [CNT_W-1:0]   period_c
);

    localparam int unsigned PW = CNT_W + LEVEL_W;

    logic [PW-1:0] prod_c;

    assign prod_c   = PW'(level) * PW'(STEP);
    assign period_c = (prod_c >= PW'(BASE_PERIOD - MIN_PERIOD))
                    ? CNT_W'(MIN_PERIOD)
                    : CNT_W'(BASE_PERIOD) - CNT_W'(prod_c);

endmodule

// File: rtl/move_tick_gen.sv
// Game-speed timebase: one-cycle tick per game step at a level-dependent period.
// Define AUTO_SPEEDUP_EN to raise the level every TICKS_PER_LEVEL ticks.
module move_tick_gen
    import snake_pkg::*;
#(
    parameter int unsigned BASE_PERIOD     = BASE_PERIOD_DEF,
    parameter int unsigned STEP            = STEP_DEF,
    parameter int unsigned MIN_PERIOD      = MIN_PERIOD_DEF,
    parameter int unsigned LEVEL_W         = LEVEL_W_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF,
    parameter int unsigned TICKS_PER_LEVEL = TICKS_PER_LEVEL_DEF
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               enable,
    input  logic               pause,
    input  logic               level_wr,
    input  logic [LEVEL_W-1:0] level_in,
    output logic               tick,
    output logic [LEVEL_W-1:0] level,
    output logic [15:0]        tick_cnt
);

    if (MIN_PERIOD < 2 || TICKS_PER_LEVEL < 1) begin : g_bad_cfg
        $error("move_tick_gen: MIN_PERIOD must be >= 2 and TICKS_PER_LEVEL >= 1");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_c;

    speed_period_calc #(
        .BASE_PERIOD (BASE_PERIOD),
        .STEP        (STEP),
        .MIN_PERIOD  (MIN_PERIOD),
        .LEVEL_W     (LEVEL_W),
        .CNT_W       (CNT_W)
    ) u_calc (
        .level    (level),
        .period_c (period_c)
    );

    // Interval FSM; a PAUSED cycle with pause released counts like RUN so the delay equals the pause length
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            tick     <= 1'b0;
            tick_cnt <= 16'd0;
            period_q <= CNT_W'(BASE_PERIOD);
            cnt      <= CNT_W'(BASE_PERIOD - 1);
        end else begin
            period_q <= period_c;
            tick     <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                cnt      <= period_q - CNT_W'(1);
                tick_cnt <= 16'd0;
            end else if (state == IDLE) begin
                state <= RUN;
                cnt   <= period_q - CNT_W'(1);
            end else if (pause) begin
                state <= PAUSED;
            end else begin
                state <= RUN;
                if (cnt == '0) begin
                    tick     <= 1'b1;
                    cnt      <= period_q - CNT_W'(1);
                    tick_cnt <= tick_cnt + 16'd1;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

`ifdef AUTO_SPEEDUP_EN
    localparam int unsigned AW = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;

    logic          tc_c;
    logic [AW-1:0] auto_cnt;

    assign tc_c = enable && (state != IDLE) && !pause && (cnt == '0);

    // Software writes win over the automatic step and restart the ticks-per-level count
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            level    <= '0;
            auto_cnt <= '0;
        end else if (level_wr) begin
            level    <= level_in;
            auto_cnt <= '0;
        end else if (!enable || state == IDLE) begin
            auto_cnt <= '0;
        end else if (tc_c) begin
            if (auto_cnt == AW'(TICKS_PER_LEVEL - 1)) begin
                auto_cnt <= '0;
                if (level != {LEVEL_W{1'b1}}) begin
                    level <= level + LEVEL_W'(1);
                end
            end else begin
                auto_cnt <= auto_cnt + AW'(1);
            end
        end
    end
`else
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            level <= '0;
        end else if (level_wr) begin
            level <= level_in;
        end
    end
`endif

endmodule

// File: tb/tb_move_tick_gen.sv
// Directed bench for move_tick_gen: expected tick cycles are queued as stimulus
// is applied and matched against every cycle of DUT output.
module tb_move_tick_gen;

    localparam int unsigned BASE = 10;
    localparam int unsigned STP  = 2;
    localparam int unsigned MINP = 3;
    localparam int unsigned LW   = 3;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          enable;
    logic          pause;
    logic          level_wr;
    logic [LW-1:0] level_in;
    logic          tick;
    logic [LW-1:0] level;
    logic [15:0]   tick_cnt;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;
    int          q[$];
    int          t;

    move_tick_gen #(
        .BASE_PERIOD     (BASE),
        .STEP            (STP),
        .MIN_PERIOD      (MINP),
        .LEVEL_W         (LW),
        .CNT_W           (32),
        .TICKS_PER_LEVEL (4)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .enable   (enable),
        .pause    (pause),
        .level_wr (level_wr),
        .level_in (level_in),
        .tick     (tick),
        .level    (level),
        .tick_cnt (tick_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock; tick and tick_cnt are compared against the scoreboard every cycle
    task automatic step();
        bit et;
        @(posedge clk);
        cyc++;
        #1;
        et = (q.size() != 0) && (q[0] == cyc);
        if (et) begin
            void'(q.pop_front());
            exp_cnt++;
        end
        chk("tick", 32'(tick), 32'(et));
        chk("tick_cnt", 32'(tick_cnt), 32'(exp_cnt));
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic wr(input logic [LW-1:0] v);
        level_wr = 1'b1;
        level_in = v;
        step();
        level_wr = 1'b0;
        chk("level_wr", 32'(level), 32'(v));
    endtask

`ifdef AUTO_SPEEDUP_EN
    function automatic int period_of(input int lv);
        return (lv * STP >= BASE - MINP) ? MINP : BASE - lv * STP;
    endfunction
`endif

    initial begin
        clr_n    = 1'b0;
        enable   = 1'b0;
        pause    = 1'b0;
        level_wr = 1'b0;
        level_in = '0;
        #1;
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_tick_cnt", 32'(tick_cnt), 32'd0);
        step();
        step();
        clr_n = 1'b1;
        step();
        step();

        // Level 0: ticks every 10 cycles after entering RUN
        enable = 1'b1;
        t = cyc + 1;
        q.push_back(t + 10);
        q.push_back(t + 20);
        q.push_back(t + 30);
        run_to(t + 30);
        chk("three_ticks_cnt", 32'(tick_cnt), 32'd3);
        chk("level0", 32'(level), 32'd0);

`ifdef AUTO_SPEEDUP_EN
        begin
            int tk[1:32];
            tk[1] = t + 10;
            tk[2] = t + 20;
            tk[3] = t + 30;
            for (int k = 3; k < 32; k++) begin
                int lv;
                lv = (k - 1) / 4;
                if (lv > 7) lv = 7;
                tk[k + 1] = tk[k] + period_of(lv);
                q.push_back(tk[k + 1]);
            end
            run_to(tk[4]);
            chk("auto_level1", 32'(level), 32'd1);
            run_to(tk[27]);
            chk("auto_level6", 32'(level), 32'd6);
            run_to(tk[28]);
            chk("auto_level7", 32'(level), 32'd7);
            run_to(tk[32]);
            chk("auto_level_sat", 32'(level), 32'd7);
        end
`else
        // Mid-interval write: current interval stays 10, then 6
        q.push_back(t + 40);
        q.push_back(t + 46);
        q.push_back(t + 52);
        run_to(t + 33);
        wr(3'd2);
        run_to(t + 52);

        // Write at terminal count: tick issued, old period for one more interval
        q.push_back(t + 58);
        q.push_back(t + 64);
        q.push_back(t + 74);
        run_to(t + 57);
        wr(3'd0);
        run_to(t + 74);
        q.push_back(t + 84);
        q.push_back(t + 94);
        q.push_back(t + 100);
        run_to(t + 83);
        wr(3'd2);
        run_to(t + 100);

        // Level 7 clamps the period to 3
        q.push_back(t + 106);
        q.push_back(t + 109);
        q.push_back(t + 112);
        q.push_back(t + 115);
        wr(3'd7);
        run_to(t + 115);

        // Back to 10, then a 5-cycle pause mid-interval delays the tick by 5
        q.push_back(t + 118);
        q.push_back(t + 133);
        wr(3'd0);
        run_to(t + 121);
        pause = 1'b1;
        run_to(t + 126);
        chk("paused_cnt", 32'(tick_cnt), 32'(exp_cnt));
        pause = 1'b0;
        run_to(t + 133);

        // Pause on the terminal-count cycle suppresses the tick until resume
        q.push_back(t + 145);
        run_to(t + 142);
        pause = 1'b1;
        run_to(t + 144);
        pause = 1'b0;
        run_to(t + 145);

        // Dropping enable clears tick_cnt; re-entry gives a fresh full interval
        run_to(t + 150);
        enable  = 1'b0;
        exp_cnt = 16'd0;
        step();
        step();
        enable = 1'b1;
        t = cyc + 1;
        q.push_back(t + 10);
        q.push_back(t + 20);
        run_to(t + 10);
        wr(3'd2);
        run_to(t + 20);
        chk("pre_reset_level", 32'(level), 32'd2);

        // Asynchronous reset between clock edges while tick is high
        #1;
        clr_n = 1'b0;
        #1;
        exp_cnt = 16'd0;
        chk("async_tick", 32'(tick), 32'd0);
        chk("async_level", 32'(level), 32'd0);
        chk("async_tick_cnt", 32'(tick_cnt), 32'd0);
        step();
        step();
        clr_n = 1'b1;
        t = cyc + 1;
        q.push_back(t + 10);
        run_to(t + 15);
`endif

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
